tc_proj_round_sat: RTL and testbench

- Pipelined stage directly downstream of the TrackletCalculator 12-bit unsigned × 18-bit signed product (30-bit signed).
- Rounds each product to the projection LSB with an arithmetic right shift, then adds a per-item signed offset.
- Saturates the result to the projection word width.
- Presents the result on a valid/ready stream to the projection writer, and counts saturation events for monitoring.

---
 rtl/tc_proj_round_sat.sv | 132 +++++++++++++
 tb/tb_tc_proj_round_sat.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tc_proj_round_sat.sv
// Projection round/offset/saturate stage: two registered stages on a valid/ready stream.
// Optional saturation counter enabled by `define TC_PROJ_ROUND_SAT_COUNT_EN.
module tc_proj_round_sat #(
   parameter int IN_W  = 30,
   parameter int SHIFT = 12,
   parameter int OUT_W = 14,
   parameter int CNT_W = 16
) (
   input  logic                    ap_clk,
   input  logic                    ap_rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic signed [IN_W-1:0]  in_prod,
   input  logic signed [OUT_W-1:0] in_offset,
   input  logic                    in_last,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [OUT_W-1:0] out_data,
   output logic                    out_sat,
   output logic                    out_last,
   input  logic                    clear_count,
   output logic [CNT_W-1:0]        sat_count
);

   localparam int S_W = IN_W - SHIFT + 2;
   localparam logic [IN_W:0] C_HALF = (IN_W+1)'(1) << (SHIFT-1);

   if (SHIFT < 1 || SHIFT >= IN_W) begin : g_bad_shift
      $error("SHIFT out of range");
   end
   if (OUT_W > IN_W - SHIFT + 1) begin : g_bad_out_w
      $error("OUT_W too wide");
   end

   logic [1:0]       r_rst_sync;
   logic             w_rst_n;
   logic [IN_W:0]    w_rnd;
   logic [S_W-1:0]   w_s;
   logic             w_s2_adv;
   logic             w_s1_adv;
   logic             w_fits;
   logic [OUT_W-1:0] w_sat_data;
   logic             w_unused_rnd;

   logic             r_s1_valid;
   logic [S_W-1:0]   r_s1_data;
   logic             r_s1_last;
   logic             r_out_valid;
   logic [OUT_W-1:0] r_out_data;
   logic             r_out_sat;
   logic             r_out_last;

   // Reset asserts immediately but releases two clocks after ap_rst_n rises.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         r_rst_sync <= 2'b00;
      end else begin
         r_rst_sync <= {r_rst_sync[0], 1'b1};
      end
   end
   assign w_rst_n = r_rst_sync[1];

   // One extra bit keeps the rounding add exact; low bits drop out in the shift.
   assign w_rnd        = {in_prod[IN_W-1], in_prod} + C_HALF;
   assign w_unused_rnd = ^w_rnd[SHIFT-1:0];
   assign w_s          = {w_rnd[IN_W], w_rnd[IN_W:SHIFT]}
                       + {{(S_W-OUT_W){in_offset[OUT_W-1]}}, in_offset};

   assign w_s2_adv = !r_out_valid || out_ready;
   assign w_s1_adv = !r_s1_valid || w_s2_adv;
   assign in_ready = w_s1_adv;

   always_ff @(posedge ap_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_s1_valid <= 1'b0;
         r_s1_data  <= '0;
         r_s1_last  <= 1'b0;
      end else if (w_s1_adv) begin
         r_s1_valid <= in_valid;
         r_s1_data  <= w_s;
         r_s1_last  <= in_last;
      end
   end

   // The value fits when every bit above the output sign bit matches it.
   assign w_fits     = (r_s1_data[S_W-1:OUT_W-1] == {(S_W-OUT_W+1){r_s1_data[S_W-1]}});
   assign w_sat_data = w_fits ? r_s1_data[OUT_W-1:0]
                     : (r_s1_data[S_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                         : {1'b0, {(OUT_W-1){1'b1}}});

   always_ff @(posedge ap_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_sat   <= 1'b0;
         r_out_last  <= 1'b0;
      end else if (w_s2_adv) begin
         r_out_valid <= r_s1_valid;
         r_out_data  <= w_sat_data;
         r_out_sat   <= !w_fits;
         r_out_last  <= r_s1_last;
      end
   end

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_sat   = r_out_sat;
   assign out_last  = r_out_last;

`ifdef TC_PROJ_ROUND_SAT_COUNT_EN
   logic             w_sat_xfer;
   logic [CNT_W-1:0] r_sat_count;

   assign w_sat_xfer = r_out_valid && out_ready && r_out_sat;

   always_ff @(posedge ap_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_sat_count <= '0;
      end else if (clear_count) begin
         r_sat_count <= w_sat_xfer ? CNT_W'(1) : '0;
      end else if (w_sat_xfer && (r_sat_count != {CNT_W{1'b1}})) begin
         r_sat_count <= r_sat_count + CNT_W'(1);
      end
   end
   assign sat_count = r_sat_count;
`else
   logic w_unused_clear;
   assign w_unused_clear = clear_count;
   assign sat_count      = '0;
`endif

endmodule

// File: tb/tb_tc_proj_round_sat.sv
// Directed bench for tc_proj_round_sat: rounding, saturation, backpressure, counter, reset.
// A second instance with CNT_W = 2 shares the stimulus to exercise counter sticking.
module tb_tc_proj_round_sat;

`ifdef TC_PROJ_ROUND_SAT_COUNT_EN
   localparam bit CNT_ON = 1'b1;
`else
   localparam bit CNT_ON = 1'b0;
`endif

   logic               ap_clk;
   logic               ap_rst_n;
   logic               in_valid;
   logic               in_ready;
   logic signed [29:0] in_prod;
   logic signed [13:0] in_offset;
   logic               in_last;
   logic               out_valid;
   logic               out_ready;
   logic signed [13:0] out_data;
   logic               out_sat;
   logic               out_last;
   logic               clear_count;
   logic [15:0]        sat_count;

   logic               d2_in_ready;
   logic               d2_out_valid;
   logic signed [13:0] d2_out_data;
   logic               d2_out_sat;
   logic               d2_out_last;
   logic [1:0]         d2_sat_count;

   int n_tests = 0;
   int n_fail  = 0;

   tc_proj_round_sat dut (
      .ap_clk      (ap_clk),
      .ap_rst_n    (ap_rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_prod     (in_prod),
      .in_offset   (in_offset),
      .in_last     (in_last),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_sat     (out_sat),
      .out_last    (out_last),
      .clear_count (clear_count),
      .sat_count   (sat_count)
   );

   tc_proj_round_sat #(.CNT_W(2)) dut_cnt2 (
      .ap_clk      (ap_clk),
      .ap_rst_n    (ap_rst_n),
      .in_valid    (in_valid),
      .in_ready    (d2_in_ready),
      .in_prod     (in_prod),
      .in_offset   (in_offset),
      .in_last     (in_last),
      .out_valid   (d2_out_valid),
      .out_ready   (out_ready),
      .out_data    (d2_out_data),
      .out_sat     (d2_out_sat),
      .out_last    (d2_out_last),
      .clear_count (clear_count),
      .sat_count   (d2_sat_count)
   );

   initial ap_clk = 1'b0;
   always #5 ap_clk = ~ap_clk;

   task automatic check_eq(input string tag, input int got, input int exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Entered just after a rising edge; leaves just after the edge that drains the item.
   task automatic send_one(input string tag, input int prod, input int off, input bit last,
                           input int exp_d, input bit exp_s, input bit clr);
      in_valid  = 1'b1;
      in_prod   = 30'(prod);
      in_offset = 14'(off);
      in_last   = last;
      @(negedge ap_clk);
      check_eq({tag, "_in_ready"}, int'(in_ready), 1);
      @(posedge ap_clk); #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      @(negedge ap_clk);
      check_eq({tag, "_latency"}, int'(out_valid), 0);
      @(negedge ap_clk);
      check_eq({tag, "_valid"}, int'(out_valid), 1);
      check_eq({tag, "_data"}, int'($signed(out_data)), exp_d);
      check_eq({tag, "_sat"}, int'(out_sat), int'(exp_s));
      check_eq({tag, "_last"}, int'(out_last), int'(last));
      clear_count = clr;
      @(posedge ap_clk); #1;
      clear_count = 1'b0;
   endtask

   task automatic check_counts(input string tag, input int exp_main, input int exp_c2);
      @(negedge ap_clk);
      check_eq({tag, "_cnt"}, int'(sat_count), CNT_ON ? exp_main : 0);
      check_eq({tag, "_cnt2"}, int'(d2_sat_count), CNT_ON ? exp_c2 : 0);
      @(posedge ap_clk); #1;
   endtask

   initial begin
      int sent;
      int rcv;
      int prev_d;
      int n_stale;
      bit prev_l;
      bit prev_stall;

      ap_rst_n    = 1'b0;
      in_valid    = 1'b0;
      in_prod     = '0;
      in_offset   = '0;
      in_last     = 1'b0;
      out_ready   = 1'b1;
      clear_count = 1'b0;

      #12;
      check_eq("rst_out_valid", int'(out_valid), 0);
      check_eq("rst_out_data", int'($signed(out_data)), 0);
      check_eq("rst_sat_count", int'(sat_count), 0);
      repeat (2) @(posedge ap_clk);
      #3 ap_rst_n = 1'b1;
      repeat (4) @(posedge ap_clk);
      #1;

      // Rounding and offset
      send_one("pos",     6144,       0,     0, 2,     0, 0);
      send_one("neg",     -6144,      0,     1, -1,    0, 0);
      send_one("off",     4095,       5,     0, 6,     0, 0);
      send_one("half",    2048,       0,     0, 1,     0, 0);
      send_one("below",   2047,       0,     0, 0,     0, 0);
      send_one("nhalf",   -2048,      0,     0, 0,     0, 0);
      send_one("nbelow",  -2049,      0,     0, -1,    0, 0);
      send_one("negoff",  40960,      -20,   1, -10,   0, 0);
      // Saturation boundaries
      send_one("satp",    536870911,  0,     0, 8191,  1, 0);
      send_one("satn",    -536870912, 0,     1, -8192, 1, 0);
      send_one("minoff",  0,          -8192, 0, -8192, 0, 0);
      send_one("maxfit",  33550336,   0,     0, 8191,  0, 0);
      send_one("over",    33554432,   0,     0, 8191,  1, 0);
      send_one("under",   -33558528,  0,     0, -8192, 1, 0);
      send_one("offsat",  409600,     8191,  0, 8191,  1, 0);
      send_one("minfit",  -33550336,  -1,    0, -8192, 0, 0);
      send_one("minover", -33550336,  -2,    0, -8192, 1, 0);

      // Counter
      clear_count = 1'b1;
      @(posedge ap_clk); #1;
      clear_count = 1'b0;
      check_counts("clr0", 0, 0);
      send_one("c1", 536870911,  0, 0, 8191,  1, 0);
      send_one("c2", -536870912, 0, 0, -8192, 1, 0);
      send_one("c3", 33554432,   0, 0, 8191,  1, 0);
      check_counts("three", 3, 3);
      clear_count = 1'b1;
      @(posedge ap_clk); #1;
      clear_count = 1'b0;
      check_counts("clr_alone", 0, 0);
      send_one("cx", 536870911, 0, 0, 8191, 1, 1);
      check_counts("clr_xfer", 1, 1);
      for (int k = 0; k < 5; k++) begin
         send_one($sformatf("s%0d", k), -536870912, 0, 0, -8192, 1, 0);
      end
      check_counts("stick", 6, 3);

      // Backpressure: out_ready low for cycles 2..5 of a 6-item burst
      sent       = 0;
      rcv        = 0;
      prev_d     = 0;
      prev_l     = 1'b0;
      prev_stall = 1'b0;
      for (int c = 0; c < 20; c++) begin
         out_ready = !(c >= 2 && c <= 5);
         in_valid  = (sent < 6);
         in_prod   = 30'((sent + 1) * 4096);
         in_offset = '0;
         in_last   = (sent == 5);
         @(negedge ap_clk);
         if (c < 10) begin
            check_eq($sformatf("bp_in_ready_c%0d", c), int'(in_ready), (c >= 2 && c <= 5) ? 0 : 1);
         end
         if (prev_stall) begin
            check_eq($sformatf("bp_hold_data_c%0d", c), int'($signed(out_data)), prev_d);
            check_eq($sformatf("bp_hold_last_c%0d", c), int'(out_last), int'(prev_l));
         end
         if (out_valid && out_ready) begin
            check_eq($sformatf("bp_data_%0d", rcv), int'($signed(out_data)), rcv + 1);
            check_eq($sformatf("bp_last_%0d", rcv), int'(out_last), (rcv == 5) ? 1 : 0);
            rcv++;
         end
         prev_stall = out_valid && !out_ready;
         prev_d     = int'($signed(out_data));
         prev_l     = out_last;
         if (in_valid && in_ready) sent++;
         @(posedge ap_clk); #1;
      end
      in_valid  = 1'b0;
      in_last   = 1'b0;
      out_ready = 1'b1;
      check_eq("bp_count", rcv, 6);

      // Asynchronous reset with two items in flight
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_prod   = 30'(536870911);
      @(posedge ap_clk); #1;
      in_prod   = 30'(8192);
      @(posedge ap_clk); #1;
      in_valid  = 1'b0;
      @(negedge ap_clk);
      check_eq("pre_rst_valid", int'(out_valid), 1);
      check_eq("pre_rst_in_ready", int'(in_ready), 0);
      @(posedge ap_clk);
      #3 ap_rst_n = 1'b0;
      #1;
      check_eq("arst_out_valid", int'(out_valid), 0);
      check_eq("arst_sat_count", int'(sat_count), 0);
      check_eq("arst_out_sat", int'(out_sat), 0);
      check_eq("arst_out_data", int'($signed(out_data)), 0);
      repeat (2) @(posedge ap_clk);
      #2 ap_rst_n = 1'b1;
      out_ready = 1'b1;
      n_stale = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge ap_clk);
         if (out_valid) n_stale++;
      end
      check_eq("no_stale", n_stale, 0);
      @(posedge ap_clk); #1;
      send_one("recover", 6144, 0, 1, 2, 0, 0);
      check_counts("post_rst", 0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
